serial_operand_sequencer: RTL and testbench



---
 rtl/serial_operand_sequencer.sv | 110 +++++++++++
 tb/tb_serial_operand_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_sequencer.sv
// Sequencer around a bit-serial full adder: shifts two captured operands out LSB-first
// and gathers the serial sum back into a parallel result. Optional carry-in: SERIAL_CIN_EN.
module serial_operand_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_CIN_EN
  input  logic             cin,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             a_bit,
  output logic             b_bit,
  output logic             carry_d,
  input  logic             s_bit,
  input  logic             cout_bit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CNT_W-1:0] cnt;
  logic             carry_out_q;
  logic             last_shift;
  logic             initial_carry;

  // The adder's carry flop loads this on the accepting edge, seeding the first sum bit.
`ifdef SERIAL_CIN_EN
  assign initial_carry = cin;
`else
  assign initial_carry = 1'b0;
`endif

  assign last_shift = (cnt == CNT_W'(WIDTH - 1));
  assign result     = res;
  assign carry_out  = carry_out_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_sh        <= '0;
      b_sh        <= '0;
      res         <= '0;
      cnt         <= '0;
      carry_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh        <= a_in;
            b_sh        <= b_in;
            res         <= '0;
            cnt         <= '0;
            carry_out_q <= 1'b0;
          end
        end
        SHIFT: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          res  <= {s_bit, res[WIDTH-1:1]};
          cnt  <= cnt + CNT_W'(1);
          if (last_shift) carry_out_q <= cout_bit;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    a_bit      = 1'b0;
    b_bit      = 1'b0;
    carry_d    = 1'b0;
    case (state)
      IDLE: begin
        carry_d = initial_carry;
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        a_bit   = a_sh[0];
        b_bit   = b_sh[0];
        carry_d = cout_bit;
        if (last_shift) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_operand_sequencer.sv
// Directed bench for serial_operand_sequencer with a behavioural bit-serial adder attached.
// Build with +define+SERIAL_CIN_EN to exercise the carry-in variant as well.
module tb_serial_operand_sequencer;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
`ifdef SERIAL_CIN_EN
  logic             cin = 1'b0;
`endif
  logic             a_bit, b_bit, carry_d, s_bit, cout_bit;
  logic             busy, done, carry_out;
  logic [WIDTH-1:0] result;
  logic             carry_q;

  int assertions = 0;
  int failures   = 0;

  serial_operand_sequencer #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
`ifdef SERIAL_CIN_EN
    .cin      (cin),
`endif
    .a_in     (a_in),
    .b_in     (b_in),
    .a_bit    (a_bit),
    .b_bit    (b_bit),
    .carry_d  (carry_d),
    .s_bit    (s_bit),
    .cout_bit (cout_bit),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out)
  );

  always #5 clock = ~clock;

  // External full adder with its carry flop, sharing clock and reset with the sequencer.
  always @(posedge clock or posedge reset) begin
    if (reset) carry_q <= 1'b0;
    else       carry_q <= carry_d;
  end
  assign s_bit    = a_bit ^ b_bit ^ carry_q;
  assign cout_bit = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic st);
    a_in  = a;
    b_in  = b;
    start = st;
  endtask

  // Launches one addition from IDLE and checks latency, busy length, done pulse and result.
  task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp_res, input logic exp_cout);
    int busy_cycles;
    @(negedge clock);
    applyStimulus(a, b, 1'b1);
    @(negedge clock);
    start = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clock);
    end
    checkOutput({tag, "_busy_cycles"}, busy_cycles, WIDTH);
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_result"}, result, exp_res);
    checkOutput({tag, "_carry_out"}, carry_out, exp_cout);
    @(negedge clock);
    checkOutput({tag, "_done_cleared"}, done, 0);
    checkOutput({tag, "_result_held"}, result, exp_res);
  endtask

  initial begin
    int busy_cycles;
    int done_count;

    // Reset state
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_carry_out", carry_out, 0);
    checkOutput("reset_carry_d", carry_d, 0);
    checkOutput("reset_a_bit", a_bit, 0);
    @(negedge clock);
    reset = 1'b0;

    // Basic additions, no carry and full ripple
    runOp("add_35_4a", 8'h35, 8'h4A, 8'h7F, 1'b0);
    runOp("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);

    // Start held high while operands change during SHIFT
    @(negedge clock);
    applyStimulus(8'h12, 8'h34, 1'b1);
    @(negedge clock);
    checkOutput("hold_first_a_bit", a_bit, 0);
    checkOutput("hold_first_b_bit", b_bit, 0);
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    busy_cycles = 0;
    done_count  = 0;
    while (busy && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clock);
    end
    checkOutput("hold_busy_cycles", busy_cycles, WIDTH);
    checkOutput("hold_done", done, 1);
    checkOutput("hold_result", result, 8'h46);
    checkOutput("hold_carry_out", carry_out, 0);
    @(negedge clock);
    checkOutput("hold_idle_busy", busy, 0);
    checkOutput("hold_idle_done", done, 0);
    @(negedge clock);
    checkOutput("hold_second_busy", busy, 1);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_count++;
      @(negedge clock);
    end
    checkOutput("hold_done_pulses", done_count, 1);
    checkOutput("hold_second_result", result, 8'hFE);
    checkOutput("hold_second_carry", carry_out, 1);

    // Asynchronous reset in SHIFT cycle 4
    @(negedge clock);
    applyStimulus(8'hAA, 8'h55, 1'b1);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("abort_pre_a_bit", a_bit, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_result", result, 0);
    checkOutput("abort_carry_out", carry_out, 0);
    checkOutput("abort_a_bit", a_bit, 0);
    checkOutput("abort_b_bit", b_bit, 0);
    checkOutput("abort_carry_d", carry_d, 0);
    @(negedge clock);
    reset = 1'b0;
    done_count = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_count++;
      @(negedge clock);
    end
    checkOutput("abort_no_done", done_count, 0);
    runOp("after_abort_01_01", 8'h01, 8'h01, 8'h02, 1'b0);

    // Back-to-back runs
    runOp("b2b_10_20", 8'h10, 8'h20, 8'h30, 1'b0);
    runOp("b2b_80_80", 8'h80, 8'h80, 8'h00, 1'b1);
    runOp("b2b_after_carry", 8'h03, 8'h04, 8'h07, 1'b0);

`ifdef SERIAL_CIN_EN
    // Carry-in variant
    cin = 1'b1;
    #1;
    checkOutput("cin_idle_carry_d", carry_d, 1);
    runOp("cin_ff_00", 8'hFF, 8'h00, 8'h00, 1'b1);
    runOp("cin_00_00", 8'h00, 8'h00, 8'h01, 1'b0);
    cin = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
